// File: rtl/deser_pkg.sv
// Shared definitions for the serial comma-aligning deserializer.
// Holds the FSM state type, the parameter defaults and the counter-width helper.
package deser_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } deser_state_e;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam logic [7:0]  DEF_COMMA    = 8'hBC;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_LOSS_CNT = 4;

  // Wide enough to hold the larger of the two thresholds without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/deser_shreg.sv
// Serial-in shift register and word bit counter.
// Presents the candidate word every sampled bit and flags the last bit of a word.
module deser_shreg
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             align_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             word_done_o
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;

  always_comb begin
    nxt_o       = {shreg_q[WIDTH-2:0], data_i};
    word_done_o = valid_i && (bitcnt_q == LAST_BIT);
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    if (valid_i) begin
      shreg_d = nxt_o;
      // Alignment pins the boundary at this bit, so the next bit starts a word.
      if (align_i || word_done_o) begin
        bitcnt_d = '0;
      end else begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

endmodule

// File: rtl/deser_align.sv
// Comma-based word aligner: hunts for the comma, confirms it LOCK_CNT times,
// then delivers non-comma words and drops lock after LOSS_CNT misaligned words.
module deser_align
  import deser_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(DEF_COMMA),
  parameter int unsigned      LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned      LOSS_CNT = DEF_LOSS_CNT
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             comma_det
);

  localparam int unsigned     CW     = cnt_width(LOCK_CNT, LOSS_CNT);
  localparam logic [CW-1:0]   LOCK_V = CW'(LOCK_CNT);
  localparam logic [CW-1:0]   LOSS_V = CW'(LOSS_CNT);

  deser_state_e     state_q, state_d;
  logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
  logic [CW-1:0]    err_cnt_q, err_cnt_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
  logic             comma_q, comma_d;

  logic [WIDTH-1:0] nxt;
  logic             word_done;
  logic             align;
  logic             is_comma;
  logic [CW-1:0]    comma_inc;
  logic [CW-1:0]    err_inc;
  logic             loss;

  deser_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .valid_i    (valid_in),
    .data_i     (data_in),
    .align_i    (align),
    .nxt_o      (nxt),
    .word_done_o(word_done)
  );

  assign is_comma  = (nxt == COMMA);
  assign comma_inc = (comma_cnt_q == '1) ? comma_cnt_q : comma_cnt_q + 1'b1;
  assign err_inc   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
  assign loss      = misalign_q && (err_inc == LOSS_V);

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    misalign_d  = misalign_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    active_d    = active_q;
    comma_d     = 1'b0;
    align       = 1'b0;
    if (valid_in) begin
      case (state_q)
        ST_HUNT: begin
          if (is_comma) begin
            align       = 1'b1;
            comma_cnt_d = CW'(1);
            state_d     = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (word_done) begin
            if (is_comma) begin
              comma_d     = 1'b1;
              comma_cnt_d = comma_inc;
              if (comma_inc == LOCK_V) begin
                state_d    = ST_LOCKED;
                active_d   = 1'b1;
                err_cnt_d  = '0;
                misalign_d = 1'b0;
              end
            end else begin
              state_d     = ST_HUNT;
              comma_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          // Completion owns this bit; a comma seen mid-word only flags the word in progress.
          if (word_done) begin
            misalign_d = 1'b0;
            err_cnt_d  = misalign_q ? err_inc : '0;
            comma_d    = is_comma;
            if (loss) begin
              state_d     = ST_HUNT;
              active_d    = 1'b0;
              err_cnt_d   = '0;
              comma_cnt_d = '0;
            end else if (!is_comma) begin
              data_d  = nxt;
              valid_d = 1'b1;
            end
          end else if (is_comma) begin
            misalign_d = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      misalign_q  <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      comma_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      misalign_q  <= misalign_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      comma_q     <= comma_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign comma_det = comma_q;

endmodule

// File: tb/tb_deser_align.sv
// Scoreboard bench for deser_align: a bit-level reference model predicts timed
// pulse and lock events; a separate monitor checks what the DUT actually presents.
module tb_deser_align;

  localparam int unsigned W     = 8;
  localparam logic [7:0]  CMA   = 8'hBC;
  localparam int          LOCKN = 4;
  localparam int          LOSSN = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       valid_in = 1'b0;
  logic       data_in  = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       comma_det;

  deser_align #(
    .WIDTH   (8),
    .COMMA   (8'hBC),
    .LOCK_CNT(4),
    .LOSS_CNT(4)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .valid_in (valid_in),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .comma_det(comma_det)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         cyc;
    bit         is_data;
    logic [7:0] data;
  } pulse_t;

  typedef struct {
    int cyc;
    bit val;
  } act_t;

  pulse_t pq[$];
  act_t   aq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: mode 0 = hunting, 1 = confirming, 2 = locked
  int         m_mode   = 0;
  logic [7:0] m_hist   = '0;
  int         m_since  = 0;
  int         m_commas = 0;
  int         m_errs   = 0;
  bit         m_flag   = 0;
  bit         m_active = 0;

  function automatic void push_pulse(input bit is_data, input logic [7:0] d);
    pulse_t e;
    e.cyc = cyc + 1; e.is_data = is_data; e.data = d;
    pq.push_back(e);
  endfunction

  function automatic void push_act(input bit v);
    act_t a;
    a.cyc = cyc + 1; a.val = v;
    aq.push_back(a);
    m_active = v;
  endfunction

  function automatic void m_reset();
    if (m_active) push_act(1'b0);
    m_mode = 0; m_hist = '0; m_since = 0; m_commas = 0; m_errs = 0; m_flag = 0;
  endfunction

  function automatic void m_bit(input bit b);
    bit lost;
    m_hist = {m_hist[6:0], b};
    if (m_mode == 0) begin
      if (m_hist == CMA) begin
        m_mode = 1; m_since = 0; m_commas = 1;
      end
    end else begin
      m_since = m_since + 1;
      if (m_since % W == 0) begin
        if (m_mode == 1) begin
          if (m_hist == CMA) begin
            m_commas = m_commas + 1;
            push_pulse(1'b0, m_hist);
            if (m_commas == LOCKN) begin
              m_mode = 2; m_errs = 0; m_flag = 0;
              push_act(1'b1);
            end
          end else begin
            m_mode = 0; m_commas = 0;
          end
        end else begin
          m_errs = m_flag ? m_errs + 1 : 0;
          m_flag = 0;
          lost = (m_errs == LOSSN);
          if (m_hist == CMA) push_pulse(1'b0, m_hist);
          else if (!lost) push_pulse(1'b1, m_hist);
          if (lost) begin
            m_mode = 0; m_errs = 0; m_commas = 0;
            push_act(1'b0);
          end
        end
      end else if (m_mode == 2 && m_hist == CMA) begin
        m_flag = 1;
      end
    end
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(1));
  endfunction

  task automatic drive(input bit rst_n, input bit v, input bit b);
    @(negedge clk_32f);
    reset = rst_n; valid_in = v; data_in = b;
    if (!rst_n) m_reset();
    else if (v) m_bit(b);
  endtask

  task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive(1'b1, 1'b1, w[i]);
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 7, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, rbit());
  endtask

  task automatic lock_up();
    for (int i = 0; i < 4; i++) send_word(CMA);
  endtask

  // Monitor: checks reset state, every pulse and every change of active
  initial begin : monitor
    pulse_t     e;
    act_t       a;
    bit         rst_s;
    bit         prev_act;
    logic [7:0] exp_dout;
    prev_act = 1'b0;
    exp_dout = '0;
    forever begin
      @(posedge clk_32f);
      rst_s = reset;
      cyc = cyc + 1;
      #1;
      if (!rst_s) begin
        exp_dout = '0;
        n_cmp++;
        if ({data_out, valid_out, active, comma_det} !== 11'd0) begin
          n_err++;
          $display("FAIL reset_state cyc=%0d: got dout=%h vo=%b act=%b cd=%b, want all 0",
                   cyc, data_out, valid_out, active, comma_det);
        end
      end
      if (valid_out || comma_det) begin
        n_cmp++;
        if (pq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse cyc=%0d: got vo=%b cd=%b dout=%h, want none",
                   cyc, valid_out, comma_det, data_out);
        end else begin
          e = pq.pop_front();
          if (e.cyc != cyc || valid_out !== e.is_data || comma_det !== !e.is_data ||
              (e.is_data && data_out !== e.data)) begin
            n_err++;
            $display("FAIL pulse cyc=%0d: got vo=%b cd=%b dout=%h, want cyc=%0d data=%b val=%h",
                     cyc, valid_out, comma_det, data_out, e.cyc, e.is_data, e.data);
          end
          if (e.is_data) exp_dout = e.data;
        end
      end
      while (pq.size() > 0 && pq[0].cyc <= cyc) begin
        e = pq.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_pulse cyc=%0d: got none, want data=%b val=%h",
                 cyc, e.is_data, e.data);
      end
      if (active !== prev_act) begin
        n_cmp++;
        if (aq.size() == 0) begin
          n_err++;
          $display("FAIL active_change cyc=%0d: got %b, want no change", cyc, active);
        end else begin
          a = aq.pop_front();
          if (a.cyc != cyc || active !== a.val) begin
            n_err++;
            $display("FAIL active_change cyc=%0d: got %b, want %b at cyc %0d",
                     cyc, active, a.val, a.cyc);
          end
        end
      end
      while (aq.size() > 0 && aq[0].cyc <= cyc) begin
        a = aq.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_active cyc=%0d: got %b, want %b", cyc, active, a.val);
      end
      prev_act = active;
      n_cmp++;
      if (data_out !== exp_dout) begin
        n_err++;
        $display("FAIL data_hold cyc=%0d: got %h, want %h", cyc, data_out, exp_dout);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] w;
    drive(1'b0, rbit(), rbit());
    drive(1'b0, rbit(), rbit());

    // 3 junk bits, four commas, then a data word
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rbit());
    lock_up();
    send_word(8'h5A);
    idle(3);

    // Fall back to hunting from the confirming state
    drive(1'b0, 1'b0, 1'b0);
    send_word(CMA); send_word(CMA); send_word(8'h00);
    idle(3);

    // Slip by one bit while locked, then relock on the shifted boundary
    send_word(CMA);
    send_word(8'h3C);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) send_word(CMA);
    send_word(8'h77);
    idle(2);

    // Stall mid-word for five cycles
    send_bits(8'hA5, 7, 5);
    idle(5);
    send_bits(8'hA5, 4, 0);
    idle(2);

    // Reset in the middle of a locked word, then a full relock
    send_bits(8'h96, 7, 3);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    send_word(8'h96);
    lock_up();
    send_word(8'hC3);
    idle(2);

    // Random traffic with commas, stalls and occasional bit slips
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(99) < 30) w = CMA;
      else w = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        if ($urandom_range(4) == 0) idle(1);
        drive(1'b1, 1'b1, w[i]);
      end
      if ($urandom_range(99) < 3) drive(1'b1, 1'b1, rbit());
    end
    idle(6);

    n_cmp++;
    if (pq.size() != 0 || aq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pulses and %0d active events pending, want 0",
               pq.size(), aq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
